// File: rtl/support_io_pkg.sv
// Shared definitions for the CPU-to-device IO switch: FSM states, default
// parameter values and the value returned for unmapped or timed-out reads.
package support_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int unsigned NDEV_DEF        = 16;
  localparam int unsigned SUB_AW_DEF      = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  localparam logic [7:0] UNMAPPED_RD = 8'hFF;

endpackage

// File: rtl/support_io_decode.sv
// Device index to active-low one-hot select; all ones when en_i is low or
// the index does not address an existing device.
module support_io_decode
  import support_io_pkg::*;
#(
  parameter int unsigned NDEV = NDEV_DEF,
  parameter int unsigned IDXW = 8 - SUB_AW_DEF
) (
  input  logic            en_i,
  input  logic [IDXW-1:0] idx_i,
  output logic [NDEV-1:0] n_sel_o
);

  always_comb begin
    n_sel_o = '1;
    for (int unsigned k = 0; k < NDEV; k++) begin
      if (en_i && (idx_i == IDXW'(k))) n_sel_o[k] = 1'b0;
    end
  end

endmodule

// File: rtl/support_io_switch.sv
// CPU IO switch: routes one CPU IO cycle to one of NDEV device ports and
// holds the CPU in wait until the device answers. Optional timeout: SUPPORT_IO_TIMEOUT_EN.
module support_io_switch
  import support_io_pkg::*;
#(
  parameter int unsigned NDEV        = NDEV_DEF,
  parameter int unsigned SUB_AW      = SUB_AW_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          A_i,
  input  logic [7:0]          D_i,
  output logic [7:0]          D_o,
  input  logic                nrd_i,
  input  logic                nwr_i,
  input  logic                niorq_i,
  output logic                nwait_o,
  output logic [SUB_AW-1:0]   A_o,
  output logic [7:0]          io_o,
  output logic [NDEV-1:0]     nrd_o,
  output logic [NDEV-1:0]     nwr_o,
  input  logic [8*NDEV-1:0]   io_i,
  input  logic [NDEV-1:0]     rdy_i,
  output logic                timeout_o,
  input  logic                timeout_clr_i
);

  localparam int unsigned IDXW = 8 - SUB_AW;

  state_e              state_q;
  logic                wr_q;
  logic [SUB_AW-1:0]   a_q;
  logic [7:0]          io_q;
  logic [7:0]          d_q;
  logic [NDEV-1:0]     nrd_q;
  logic [NDEV-1:0]     nwr_q;

  logic                req;
  logic                req_wr;
  logic [IDXW-1:0]     idx_w;
  logic                mapped;
  logic [NDEV-1:0]     sel_n;
  logic                rdy_hit;
  logic [7:0]          rd_data;
  logic                expire;

  assign req    = ~niorq_i & (~nrd_i | ~nwr_i);
  assign req_wr = ~nwr_i;
  assign idx_w  = A_i[7:SUB_AW];
  assign mapped = (32'(idx_w) < NDEV);

  support_io_decode #(
    .NDEV (NDEV),
    .IDXW (IDXW)
  ) u_decode (
    .en_i    (mapped),
    .idx_i   (idx_w),
    .n_sel_o (sel_n)
  );

  // The latched strobes themselves carry the selected device, so ready and
  // read data are picked by the low strobe bit rather than a stored index.
  assign rdy_hit = |(rdy_i & ~(nrd_q & nwr_q));

  always_comb begin
    rd_data = UNMAPPED_RD;
    for (int unsigned k = 0; k < NDEV; k++) begin
      if (!nrd_q[k]) rd_data = io_i[8*k +: 8];
    end
  end

`ifdef SUPPORT_IO_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        to_q;

  assign expire = (state_q == ST_STROBE) && !rdy_hit &&
                  (cnt_q == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE)        cnt_d = '0;
    else if (state_q == ST_STROBE) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (expire)             to_q <= 1'b1;
      else if (timeout_clr_i) to_q <= 1'b0;
    end
  end

  assign timeout_o = to_q;
`else
  logic unused_clr;
  assign unused_clr = timeout_clr_i;
  assign expire     = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      a_q     <= '0;
      io_q    <= '0;
      d_q     <= UNMAPPED_RD;
      nrd_q   <= '1;
      nwr_q   <= '1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            wr_q <= req_wr;
            a_q  <= A_i[SUB_AW-1:0];
            io_q <= D_i;
            if (mapped) begin
              state_q <= ST_STROBE;
              nrd_q   <= req_wr ? '1 : sel_n;
              nwr_q   <= req_wr ? sel_n : '1;
            end else begin
              state_q <= ST_DONE;
              if (!req_wr) d_q <= UNMAPPED_RD;
            end
          end
        end
        ST_STROBE: begin
          if (rdy_hit || expire) begin
            state_q <= ST_DONE;
            nrd_q   <= '1;
            nwr_q   <= '1;
            if (!wr_q) d_q <= rdy_hit ? rd_data : UNMAPPED_RD;
          end
        end
        ST_DONE: begin
          if (!req) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign nwait_o = rst_i | ~(((state_q == ST_IDLE) && req) || (state_q == ST_STROBE));

  assign A_o   = a_q;
  assign io_o  = io_q;
  assign D_o   = d_q;
  assign nrd_o = nrd_q;
  assign nwr_o = nwr_q;

endmodule

// File: tb/tb_support_io_switch.sv
// Randomized bench for support_io_switch against a transaction-level model
// (strobe width, returned data, sticky timeout). Honours SUPPORT_IO_TIMEOUT_EN.
module tb_support_io_switch;

  localparam int unsigned NDEV   = 12;
  localparam int unsigned SUB_AW = 4;
  localparam int unsigned TO     = 6;

  logic                clk = 1'b0;
  logic                rst_i;
  logic [7:0]          A_i, D_i, D_o;
  logic                nrd_i, nwr_i, niorq_i, nwait_o;
  logic [SUB_AW-1:0]   A_o;
  logic [7:0]          io_o;
  logic [NDEV-1:0]     nrd_o, nwr_o, rdy_i;
  logic [8*NDEV-1:0]   io_i;
  logic                timeout_o, timeout_clr_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  cur_addr, cur_data;
  bit          cur_wr;
  int unsigned cur_delay;
  logic [7:0]  exp_do;
  bit          exp_to;

  always #5 clk = ~clk;

  support_io_switch #(
    .NDEV        (NDEV),
    .SUB_AW      (SUB_AW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .A_i           (A_i),
    .D_i           (D_i),
    .D_o           (D_o),
    .nrd_i         (nrd_i),
    .nwr_i         (nwr_i),
    .niorq_i       (niorq_i),
    .nwait_o       (nwait_o),
    .A_o           (A_o),
    .io_o          (io_o),
    .nrd_o         (nrd_o),
    .nwr_o         (nwr_o),
    .io_i          (io_i),
    .rdy_i         (rdy_i),
    .timeout_o     (timeout_o),
    .timeout_clr_i (timeout_clr_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; drives a request and fresh device data.
  task automatic drive_req(input logic [7:0] addr, input bit wr, input bit both,
                           input logic [7:0] data, input int unsigned delay);
    cur_addr  = addr;
    cur_wr    = wr;
    cur_data  = data;
    cur_delay = delay;
    for (int unsigned k = 0; k < NDEV; k++) io_i[8*k +: 8] = 8'($urandom);
    rdy_i   = '0;
    A_i     = addr;
    D_i     = data;
    niorq_i = 1'b0;
    nwr_i   = wr ? 1'b0 : 1'b1;
    nrd_i   = (wr && !both) ? 1'b1 : 1'b0;
  endtask

  task automatic finish_txn();
    int unsigned     dev, width, exp_w;
    bit              done, tmo;
    logic [NDEV-1:0] onehot, all1, exp_rd, exp_wr;
    dev    = 32'(cur_addr) >> SUB_AW;
    all1   = '1;
    onehot = '1;
    if (dev < NDEV) onehot[dev] = 1'b0;
    exp_rd = cur_wr ? all1 : onehot;
    exp_wr = cur_wr ? onehot : all1;
    tmo    = 1'b0;
    if (dev >= NDEV) exp_w = 0;
    else begin
      exp_w = cur_delay + 1;
`ifdef SUPPORT_IO_TIMEOUT_EN
      if (cur_delay >= TO) begin
        exp_w = TO;
        tmo   = 1'b1;
      end
`endif
    end

    @(negedge clk);
    chk("req_nwait", 32'(nwait_o), 32'd0);
    width = 0;
    done  = 1'b0;
    for (int unsigned c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      if (dev < NDEV) rdy_i[dev] = (width == cur_delay);
      @(negedge clk);
      if (nwait_o) done = 1'b1;
      else begin
        width++;
        chk("nrd_strobe", 32'(nrd_o), 32'(exp_rd));
        chk("nwr_strobe", 32'(nwr_o), 32'(exp_wr));
        if (width == 1) begin
          A_i = 8'($urandom);
          D_i = 8'($urandom);
        end
      end
    end
    if (!done) chk("done_bound", 32'd0, 32'd1);

    if (!cur_wr) exp_do = (dev < NDEV && !tmo) ? io_i[8*dev +: 8] : 8'hFF;
    if (tmo) exp_to = 1'b1;

    chk("strobe_width", width, exp_w);
    chk("done_nrd", 32'(nrd_o), 32'(all1));
    chk("done_nwr", 32'(nwr_o), 32'(all1));
    chk("A_o", 32'(A_o), 32'(cur_addr[SUB_AW-1:0]));
    chk("io_o", 32'(io_o), 32'(cur_data));
    chk("D_o", 32'(D_o), 32'(exp_do));
    chk("timeout_o", 32'(timeout_o), 32'(exp_to));

    @(posedge clk); #1;
    niorq_i = 1'b1;
    nrd_i   = 1'b1;
    nwr_i   = 1'b1;
    rdy_i   = '0;
    @(negedge clk);
    chk("release_nwait", 32'(nwait_o), 32'd1);
    chk("hold_D_o", 32'(D_o), 32'(exp_do));
    @(posedge clk); #1;
  endtask

  task automatic txn(input logic [7:0] addr, input bit wr, input bit both,
                     input logic [7:0] data, input int unsigned delay);
    drive_req(addr, wr, both, data, delay);
    finish_txn();
  endtask

  initial begin
    rst_i = 1'b1; A_i = '0; D_i = '0; nrd_i = 1'b1; nwr_i = 1'b1; niorq_i = 1'b1;
    io_i = '0; rdy_i = '0; timeout_clr_i = 1'b0;
    exp_do = 8'hFF; exp_to = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_nrd", 32'(nrd_o), 32'hFFF);
    chk("rst_nwr", 32'(nwr_o), 32'hFFF);
    chk("rst_nwait", 32'(nwait_o), 32'd1);
    chk("rst_D_o", 32'(D_o), 32'hFF);
    chk("rst_A_o", 32'(A_o), 32'd0);
    chk("rst_io_o", 32'(io_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;

    txn(8'h35, 1'b0, 1'b0, 8'h00, 0);
    txn(8'hB2, 1'b1, 1'b0, 8'h5C, 4);
    txn(8'hC0, 1'b0, 1'b0, 8'h11, 0);
    txn(8'hF7, 1'b0, 1'b0, 8'h22, 3);
    txn(8'h10, 1'b1, 1'b1, 8'h77, 1);
    txn(8'h01, 1'b0, 1'b0, 8'h00, TO + 2);
    txn(8'h45, 1'b1, 1'b0, 8'h9A, TO - 1);

    @(posedge clk); #1;
    timeout_clr_i = 1'b1;
    @(posedge clk); #1;
    timeout_clr_i = 1'b0;
    exp_to = 1'b0;
    @(negedge clk);
    chk("timeout_clr", 32'(timeout_o), 32'(exp_to));
    @(posedge clk); #1;

    // Clear held across an expiring read: the set must win.
    timeout_clr_i = 1'b1;
    txn(8'h2A, 1'b0, 1'b0, 8'h00, TO + 1);
    timeout_clr_i = 1'b0;

    // Reset in the middle of a write strobe, request held through release.
    drive_req(8'h27, 1'b1, 1'b0, 8'h3C, 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_nwr", 32'(nwr_o), 32'hFFB);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_nwr", 32'(nwr_o), 32'hFFF);
    chk("midrst_nwait", 32'(nwait_o), 32'd1);
    chk("midrst_D_o", 32'(D_o), 32'hFF);
    chk("midrst_io_o", 32'(io_o), 32'd0);
    chk("midrst_timeout", 32'(timeout_o), 32'd0);
    exp_do = 8'hFF;
    exp_to = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    finish_txn();

    for (int unsigned i = 0; i < 40; i++) begin
      logic [7:0] a;
      a = 8'($urandom);
      txn(a, 1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, TO + 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
